// File: rtl/sbinit_pattern_fsm_pkg.sv
// Shared constants and state encoding for the SBINIT sideband clock-pattern stage.
package sbinit_pattern_fsm_pkg;

    localparam int SB_PATTERN_UI         = 64;
    localparam int SB_IDLE_UI            = 32;
    localparam int SB_DETECT_ITER        = 2;
    localparam int SB_TAIL_ITER          = 4;
    localparam int SB_SBINIT_TIMEOUT_CYC = 6400000;

    typedef enum logic [2:0] {
        SBINIT_IDLE      = 3'd0,
        SBINIT_SEND_PAT  = 3'd1,
        SBINIT_SEND_IDLE = 3'd2,
        SBINIT_TAIL_PAT  = 3'd3,
        SBINIT_TAIL_IDLE = 3'd4,
        SBINIT_DONE      = 3'd5,
        SBINIT_TIMEOUT   = 3'd6
    } sbinit_state_t;

    // Resting states are the only ones that accept a new start.
    function automatic logic sbinit_is_busy(input sbinit_state_t s);
        return !(s inside {SBINIT_IDLE, SBINIT_DONE, SBINIT_TIMEOUT});
    endfunction

    function automatic logic sbinit_drives_pattern(input sbinit_state_t s);
        return (s == SBINIT_SEND_PAT) || (s == SBINIT_TAIL_PAT);
    endfunction

endpackage

// File: rtl/sbinit_pattern_fsm_detector.sv
// RX clock-pattern checker: verifies alternating data while the partner clock is forwarded
// and pulses good/bad once per burst.
module sbinit_pattern_fsm_detector
    import sbinit_pattern_fsm_pkg::*;
#(
    parameter int PATTERN_UI = SB_PATTERN_UI
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic rx_clk,
    input  logic rx_data,
    output logic good_pulse,
    output logic bad_pulse
);

    localparam int RUN_W = $clog2(PATTERN_UI + 1);

    logic [RUN_W-1:0] run_cnt_r;
    logic             prev_bit_r;
    logic             prev_clk_r;
    logic             err_r;
    logic             full_s;
    logic             expect_s;

    assign full_s   = (run_cnt_r == RUN_W'(PATTERN_UI));
    assign expect_s = (run_cnt_r == '0) ? 1'b1 : ~prev_bit_r;

    // Run-length tracking; an errored burst is ignored until the clock drops again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_r  <= '0;
            prev_bit_r <= 1'b0;
            prev_clk_r <= 1'b0;
            err_r      <= 1'b0;
            good_pulse <= 1'b0;
            bad_pulse  <= 1'b0;
        end else if (clear || !active) begin
            run_cnt_r  <= '0;
            prev_bit_r <= 1'b0;
            prev_clk_r <= 1'b0;
            err_r      <= 1'b0;
            good_pulse <= 1'b0;
            bad_pulse  <= 1'b0;
        end else begin
            good_pulse <= 1'b0;
            bad_pulse  <= 1'b0;
            prev_clk_r <= rx_clk;
            prev_bit_r <= rx_data;
            if (rx_clk) begin
                if (!err_r && !full_s) begin
                    if (rx_data != expect_s) begin
                        err_r     <= 1'b1;
                        bad_pulse <= 1'b1;
                        run_cnt_r <= '0;
                    end else begin
                        run_cnt_r  <= run_cnt_r + 1'b1;
                        good_pulse <= (run_cnt_r == RUN_W'(PATTERN_UI - 1));
                    end
                end
            end else begin
                bad_pulse <= prev_clk_r && !full_s && !err_r;
                run_cnt_r <= '0;
                err_r     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sbinit_pattern_fsm.sv
// SBINIT sideband clock-pattern stage: sends pattern/idle iterations, waits for partner
// detection, sends the tail and reports done or timeout.
module sbinit_pattern_fsm
    import sbinit_pattern_fsm_pkg::*;
#(
    parameter int PATTERN_UI  = SB_PATTERN_UI,
    parameter int IDLE_UI     = SB_IDLE_UI,
    parameter int DETECT_ITER = SB_DETECT_ITER,
    parameter int TAIL_ITER   = SB_TAIL_ITER,
    parameter int TIMEOUT_CYC = SB_SBINIT_TIMEOUT_CYC
) (
    input  logic clk_800MHz,
    input  logic reset,
    input  logic enable_i,
    input  logic start_i,
    input  logic SB_clkPin_RX_i,
    input  logic SB_dataPin_RX_i,
    output logic SB_clkPin_TX_o,
    output logic SB_dataPin_TX_o,
    output logic busy_o,
    output logic pattern_detected_o,
    output logic done_o,
    output logic timeout_o
);

    localparam int UI_MAX = (PATTERN_UI > IDLE_UI) ? PATTERN_UI : IDLE_UI;
    localparam int UI_W   = $clog2(UI_MAX);
    localparam int IT_W   = $clog2(TAIL_ITER + 1);
    localparam int GD_W   = $clog2(DETECT_ITER + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    sbinit_state_t   state_r;
    logic [UI_W-1:0] ui_cnt_r;
    logic [IT_W-1:0] iter_cnt_r;
    logic [GD_W-1:0] good_cnt_r;
    logic [TO_W-1:0] timeout_cnt_r;
    logic            good_pulse_s;
    logic            bad_pulse_s;
    logic            start_accept_s;
    logic            det_active_s;
    logic            detect_now_s;
    logic            timeout_hit_s;

    assign start_accept_s = start_i && enable_i && !sbinit_is_busy(state_r);
    assign det_active_s   = ((state_r == SBINIT_SEND_PAT) || (state_r == SBINIT_SEND_IDLE))
                            && !pattern_detected_o;
    assign detect_now_s   = (good_cnt_r == GD_W'(DETECT_ITER));
    // Detection in the same cycle suppresses the timeout.
    assign timeout_hit_s  = !pattern_detected_o && !detect_now_s
                            && (timeout_cnt_r == TO_W'(TIMEOUT_CYC - 1));

    sbinit_pattern_fsm_detector #(
        .PATTERN_UI (PATTERN_UI)
    ) u_detector (
        .clk        (clk_800MHz),
        .reset      (reset),
        .clear      (start_accept_s || !enable_i),
        .active     (det_active_s),
        .rx_clk     (SB_clkPin_RX_i),
        .rx_data    (SB_dataPin_RX_i),
        .good_pulse (good_pulse_s),
        .bad_pulse  (bad_pulse_s)
    );

    // Sequencer: state, UI/iteration/timeout counters, sticky flags and registered pins.
    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            state_r            <= SBINIT_IDLE;
            ui_cnt_r           <= '0;
            iter_cnt_r         <= '0;
            good_cnt_r         <= '0;
            timeout_cnt_r      <= '0;
            SB_clkPin_TX_o     <= 1'b0;
            SB_dataPin_TX_o    <= 1'b0;
            busy_o             <= 1'b0;
            pattern_detected_o <= 1'b0;
            done_o             <= 1'b0;
            timeout_o          <= 1'b0;
        end else if (!enable_i) begin
            state_r            <= SBINIT_IDLE;
            ui_cnt_r           <= '0;
            iter_cnt_r         <= '0;
            good_cnt_r         <= '0;
            timeout_cnt_r      <= '0;
            SB_clkPin_TX_o     <= 1'b0;
            SB_dataPin_TX_o    <= 1'b0;
            busy_o             <= 1'b0;
            pattern_detected_o <= 1'b0;
            done_o             <= 1'b0;
            timeout_o          <= 1'b0;
        end else begin
            SB_clkPin_TX_o  <= sbinit_drives_pattern(state_r);
            SB_dataPin_TX_o <= sbinit_drives_pattern(state_r) && !ui_cnt_r[0];
            case (state_r)
                SBINIT_IDLE, SBINIT_DONE, SBINIT_TIMEOUT: begin
                    if (start_i) begin
                        state_r            <= SBINIT_SEND_PAT;
                        ui_cnt_r           <= '0;
                        iter_cnt_r         <= '0;
                        good_cnt_r         <= '0;
                        timeout_cnt_r      <= '0;
                        busy_o             <= 1'b1;
                        pattern_detected_o <= 1'b0;
                        done_o             <= 1'b0;
                        timeout_o          <= 1'b0;
                    end
                end
                SBINIT_SEND_PAT, SBINIT_SEND_IDLE: begin
                    if (!pattern_detected_o) begin
                        if (detect_now_s) begin
                            pattern_detected_o <= 1'b1;
                        end else if (good_pulse_s) begin
                            good_cnt_r <= good_cnt_r + 1'b1;
                        end else if (bad_pulse_s) begin
                            good_cnt_r <= '0;
                        end
                        timeout_cnt_r <= timeout_cnt_r + 1'b1;
                    end
                    if (timeout_hit_s) begin
                        state_r   <= SBINIT_TIMEOUT;
                        ui_cnt_r  <= '0;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else if (state_r == SBINIT_SEND_PAT) begin
                        if (ui_cnt_r == UI_W'(PATTERN_UI - 1)) begin
                            ui_cnt_r <= '0;
                            state_r  <= SBINIT_SEND_IDLE;
                        end else begin
                            ui_cnt_r <= ui_cnt_r + 1'b1;
                        end
                    end else if (ui_cnt_r == UI_W'(IDLE_UI - 1)) begin
                        ui_cnt_r   <= '0;
                        iter_cnt_r <= '0;
                        state_r    <= pattern_detected_o ? SBINIT_TAIL_PAT : SBINIT_SEND_PAT;
                    end else begin
                        ui_cnt_r <= ui_cnt_r + 1'b1;
                    end
                end
                SBINIT_TAIL_PAT: begin
                    if (ui_cnt_r == UI_W'(PATTERN_UI - 1)) begin
                        ui_cnt_r <= '0;
                        state_r  <= SBINIT_TAIL_IDLE;
                    end else begin
                        ui_cnt_r <= ui_cnt_r + 1'b1;
                    end
                end
                SBINIT_TAIL_IDLE: begin
                    if (ui_cnt_r == UI_W'(IDLE_UI - 1)) begin
                        ui_cnt_r <= '0;
                        if (iter_cnt_r == IT_W'(TAIL_ITER - 1)) begin
                            state_r <= SBINIT_DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            iter_cnt_r <= iter_cnt_r + 1'b1;
                            state_r    <= SBINIT_TAIL_PAT;
                        end
                    end else begin
                        ui_cnt_r <= ui_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= SBINIT_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbinit_pattern_fsm.sv
// Scoreboard bench for sbinit_pattern_fsm: stimulus queues expected status transitions and
// output samples, an independent negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sbinit_pattern_fsm;

    logic clk = 1'b0;
    logic reset, enable, start, loop_en, rx_clk_drv, rx_data_drv;
    logic rx_clk, rx_data, clk_tx, data_tx, busy, det, done, tmo;
    int   cyc = 0;
    int   t0 = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct { string name; logic [3:0] st; int lo; int hi; } stat_exp_t;
    typedef struct { string name; logic [5:0] val; logic [5:0] mask; bit drain; } samp_exp_t;
    stat_exp_t  stat_q[$];
    samp_exp_t  samp_q[$];
    logic [3:0] prev_st = 4'b0000;

    assign rx_clk  = loop_en ? clk_tx  : rx_clk_drv;
    assign rx_data = loop_en ? data_tx : rx_data_drv;

    sbinit_pattern_fsm #(
        .PATTERN_UI (8), .IDLE_UI (4), .DETECT_ITER (2), .TAIL_ITER (4), .TIMEOUT_CYC (200)
    ) dut (
        .clk_800MHz         (clk),
        .reset              (reset),
        .enable_i           (enable),
        .start_i            (start),
        .SB_clkPin_RX_i     (rx_clk),
        .SB_dataPin_RX_i    (rx_data),
        .SB_clkPin_TX_o     (clk_tx),
        .SB_dataPin_TX_o    (data_tx),
        .busy_o             (busy),
        .pattern_detected_o (det),
        .done_o             (done),
        .timeout_o          (tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every status change pops one expected transition; queued samples are compared.
    always @(negedge clk) begin
        logic [3:0] st;
        logic [5:0] outs;
        int         rel;
        stat_exp_t  e;
        samp_exp_t  s;
        st   = {busy, det, done, tmo};
        outs = {clk_tx, data_tx, st};
        rel  = cyc - t0;
        if (st !== prev_st) begin
            n_checks++;
            if (stat_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_status: got %b at rel cycle %0d, required no change from %b",
                         st, rel, prev_st);
            end else begin
                e = stat_q.pop_front();
                if (st !== e.st || rel < e.lo || rel > e.hi) begin
                    n_fail++;
                    $display("FAIL %s: got status %b at rel cycle %0d, required %b within [%0d,%0d]",
                             e.name, st, rel, e.st, e.lo, e.hi);
                end
            end
            prev_st = st;
        end
        while (samp_q.size() != 0) begin
            s = samp_q.pop_front();
            n_checks++;
            if (s.drain) begin
                if (stat_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL drain: %0d status transitions never seen, required 0", stat_q.size());
                end
            end else if ((outs & s.mask) !== (s.val & s.mask)) begin
                n_fail++;
                $display("FAIL %s: got outputs %b at rel cycle %0d, required %b (mask %b)",
                         s.name, outs, rel, s.val, s.mask);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rel(input int r);
        while (cyc - t0 < r) tick(1);
    endtask

    task automatic expect_st(input string nm, input logic [3:0] st, input int lo, input int hi);
        stat_exp_t e;
        e.name = nm; e.st = st; e.lo = lo; e.hi = hi;
        stat_q.push_back(e);
    endtask

    // Output vector order: {clk_tx, data_tx, busy, detected, done, timeout}.
    task automatic expect_out(input string nm, input logic [5:0] val);
        samp_exp_t s;
        s.name = nm; s.val = val; s.mask = 6'b111111; s.drain = 1'b0;
        samp_q.push_back(s);
    endtask

    task automatic do_start();
        start = 1'b1;
        t0    = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic burst(input int len, input int err_at);
        for (int i = 0; i < len; i++) begin
            rx_clk_drv  = 1'b1;
            rx_data_drv = ((i % 2) == 0) ^ (i == err_at);
            tick(1);
        end
    endtask

    task automatic gap(input int n);
        rx_clk_drv  = 1'b0;
        rx_data_drv = 1'b0;
        tick(n);
    endtask

    // Directed scenarios; timing is relative to the cycle in which start_i is driven.
    initial begin
        samp_exp_t dr;
        reset = 1'b0; enable = 1'b1; start = 1'b0; loop_en = 1'b0;
        rx_clk_drv = 1'b0; rx_data_drv = 1'b0;
        tick(3);
        expect_out("reset_state", 6'b000000);
        tick(1);
        reset = 1'b1;
        tick(2);

        // Loopback: detection after the second burst, four tail iterations, done at 73.
        loop_en = 1'b1;
        expect_st("lb_busy", 4'b1000, 1, 1);
        expect_st("lb_detect", 4'b1100, 22, 25);
        expect_st("lb_done", 4'b0110, 73, 74);
        do_start();
        wait_rel(2);  expect_out("lb_pin_ui0", 6'b111000);
        wait_rel(3);  expect_out("lb_pin_ui1", 6'b101000);
        wait_rel(9);  expect_out("lb_pin_ui7", 6'b101000);
        wait_rel(10); expect_out("lb_pin_idle", 6'b001000);
        wait_rel(30); expect_out("lb_tail_pin", 6'b111100);
        wait_rel(80); expect_out("lb_done_pins", 6'b000110);

        // Start while busy is ignored; enable low during TAIL_PAT aborts to IDLE.
        expect_st("ab_busy", 4'b1000, 1, 1);
        expect_st("ab_detect", 4'b1100, 22, 25);
        expect_st("ab_disable", 4'b0000, 29, 29);
        do_start();
        wait_rel(10);
        start = 1'b1; tick(1); start = 1'b0;
        wait_rel(28);
        enable = 1'b0;
        tick(1);
        wait_rel(35); expect_out("ab_idle", 6'b000000);
        enable = 1'b1;
        tick(3);

        // RX tied low: timeout after TIMEOUT_CYC, then a new start clears it.
        loop_en = 1'b0;
        expect_st("to_busy", 4'b1000, 1, 1);
        expect_st("to_fire", 4'b0001, 200, 201);
        do_start();
        wait_rel(205); expect_out("to_state", 6'b000001);
        expect_st("to_restart", 4'b1000, 1, 1);
        expect_st("to_disable", 4'b0000, 6, 6);
        do_start();
        wait_rel(5);
        enable = 1'b0; tick(1); enable = 1'b1;
        tick(3);

        // Bit error at UI 5 of the first burst: detection only after two later clean bursts.
        expect_st("be_busy", 4'b1000, 1, 1);
        expect_st("be_detect", 4'b1100, 35, 35);
        expect_st("be_done", 4'b0110, 85, 86);
        do_start();
        burst(8, 5); gap(4);
        burst(8, -1); gap(4);
        burst(8, -1); gap(4);
        wait_rel(90);

        // Clock drop after 6 UI clears the good count earned by the preceding burst.
        expect_st("cd_busy", 4'b1000, 1, 1);
        expect_st("cd_detect", 4'b1100, 47, 47);
        expect_st("cd_done", 4'b0110, 97, 98);
        do_start();
        burst(8, -1); gap(4);
        burst(6, -1); gap(6);
        burst(8, -1); gap(4);
        burst(8, -1); gap(4);
        wait_rel(100);

        // Asynchronous reset mid-SEND_PAT, then a clean restart.
        loop_en = 1'b1;
        expect_st("rs_busy", 4'b1000, 1, 1);
        expect_st("rs_reset", 4'b0000, 4, 4);
        do_start();
        wait_rel(4);
        reset = 1'b0;
        expect_out("rs_immediate", 6'b000000);
        tick(2);
        reset = 1'b1;
        tick(3);
        expect_out("rs_idle", 6'b000000);
        tick(1);
        expect_st("rs_restart", 4'b1000, 1, 1);
        expect_st("rs_disable", 4'b0000, 5, 5);
        do_start();
        wait_rel(3); expect_out("rs_restart_pin", 6'b101000);
        tick(1);
        enable = 1'b0; tick(1); enable = 1'b1;
        tick(2);

        dr.name = "drain"; dr.val = 6'b000000; dr.mask = 6'b000000; dr.drain = 1'b1;
        samp_q.push_back(dr);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
